stream_parity_acc: RTL

- Streaming, parametrised successor to the combinational XOR/XNOR reduction cells.
- Accumulates even/odd parity over a multi-beat frame of WIDTH-bit words, in both directions:
  - across all bits of the frame (total parity);
  - per bit column across beats (column parity).
- Presents a registered result per frame on a valid/ready output.
- Sits as a check/generate stage on datapath frames; exercised by the simulation tests alongside the reduction cells.

---
 rtl/parity_pkg.sv | 18 +
 rtl/parity_reduce.sv | 13 +
 rtl/stream_parity_acc.sv | 122 ++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the parity reduction family: INVERT mode values and
// the beat-counter width helper.
package parity_pkg;

  localparam int unsigned PAR_MODE_XOR  = 32'd0;
  localparam int unsigned PAR_MODE_XNOR = 32'd1;

  // Smallest width able to hold the value maxwords (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned maxwords);
    int unsigned w;
    w = 32'd1;
    while ((w < 32'd32) && ((64'd1 << w) <= 64'(maxwords))) begin
      w = w + 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/parity_reduce.sv
// Combinational WIDTH-bit XOR reduction with optional output inversion; the
// parametrised form of the fixed 2/3/4-input reduction cells.
module parity_reduce #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             invert_i,
  output logic             parity_o
);

  assign parity_o = (^data_i) ^ invert_i;

endmodule

// File: rtl/stream_parity_acc.sv
// Streaming frame parity accumulator: total and per-column parity over
// multi-beat frames, one registered result per frame on a valid/ready port.
module stream_parity_acc
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned INVERT   = PAR_MODE_XNOR,
  parameter int unsigned MAXWORDS = 255,
  parameter int unsigned CNT_W    = cnt_width(MAXWORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [WIDTH-1:0] out_column,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic             INV_BIT = (INVERT != PAR_MODE_XOR) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAXWORDS);

  logic [WIDTH-1:0] col_acc_q, col_acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             out_parity_q, out_parity_d;
  logic [WIDTH-1:0] out_column_q, out_column_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             beat_fire_s;
  logic [WIDTH-1:0] col_sum_s;
  logic             cnt_sat_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             par_s;

  // A pending result only blocks input while the consumer is stalling it.
  assign in_ready    = !out_valid_q || out_ready;
  assign beat_fire_s = in_valid && in_ready;
  assign col_sum_s   = col_acc_q ^ in_data;
  assign cnt_sat_s   = (cnt_q == MAX_CNT);
  assign cnt_inc_s   = cnt_sat_s ? cnt_q : (cnt_q + CNT_W'(1));

  // Total parity comes from the column sum, so both results agree by construction.
  parity_reduce #(
    .WIDTH (WIDTH)
  ) u_reduce (
    .data_i   (col_sum_s),
    .invert_i (INV_BIT),
    .parity_o (par_s)
  );

  // Next-state: accumulate on middle beats, publish and clear on the last beat.
  always_comb begin
    col_acc_d    = col_acc_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    out_parity_d = out_parity_q;
    out_column_d = out_column_q;
    out_count_d  = out_count_q;
    out_ovf_d    = out_ovf_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (beat_fire_s) begin
      if (in_last) begin
        col_acc_d    = {WIDTH{1'b0}};
        cnt_d        = {CNT_W{1'b0}};
        ovf_d        = 1'b0;
        out_valid_d  = 1'b1;
        out_parity_d = par_s;
        out_column_d = col_sum_s ^ {WIDTH{INV_BIT}};
        out_count_d  = cnt_inc_s;
        out_ovf_d    = ovf_q | cnt_sat_s;
      end else begin
        col_acc_d = col_sum_s;
        cnt_d     = cnt_inc_s;
        ovf_d     = ovf_q | cnt_sat_s;
      end
    end else begin
      col_acc_d = col_acc_q;
    end
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_acc_q    <= {WIDTH{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_parity_q <= 1'b0;
      out_column_q <= {WIDTH{1'b0}};
      out_count_q  <= {CNT_W{1'b0}};
      out_ovf_q    <= 1'b0;
    end else begin
      col_acc_q    <= col_acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      out_valid_q  <= out_valid_d;
      out_parity_q <= out_parity_d;
      out_column_q <= out_column_d;
      out_count_q  <= out_count_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_parity = out_parity_q;
  assign out_column = out_column_q;
  assign out_count  = out_count_q;
  assign out_ovf    = out_ovf_q;

endmodule
